// File: rtl/mlsu_resp_merger.sv
// mlsu_resp_merger
// Merges MLSU load and store completion pulses into one ordered response
// stream for the sequencer. Neither pulse source can be stalled, so
// responses are buffered in a small circular FIFO. Pulses that find no room
// are dropped and latched into a sticky overflow flag. The issue path is
// throttled early through req_stall_o.

module mlsu_resp_merger #(
  parameter int IdWidth = 5,
  parameter int Depth   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ld_resp_valid_i,
  input  logic [IdWidth-1:0]         ld_resp_id_i,
  input  logic                       st_resp_valid_i,
  input  logic [IdWidth-1:0]         st_resp_id_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [IdWidth-1:0]         resp_id_o,
  output logic                       resp_is_load_o,
  output logic                       req_stall_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [IdWidth-1:0] id_mem_q [Depth];
  logic [IdWidth-1:0] id_mem_d [Depth];
  logic               ld_mem_q [Depth];
  logic               ld_mem_d [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [CntW-1:0]    free_slots;
  logic               ld_accept;
  logic               st_accept;
  logic               deq;
  logic [1:0]         enq_num;
  logic [PtrW-1:0]    st_ptr;

  // Admission, storage writes and pointer/counter updates. Free room is taken
  // from the registered count so a same-cycle dequeue never makes room, and
  // the load entry always lands first so it is the older of a pair.
  always_comb begin
    free_slots = DepthCnt - count_q;
    ld_accept  = ld_resp_valid_i && (free_slots != '0);
    st_accept  = st_resp_valid_i &&
                 (ld_resp_valid_i ? (free_slots >= CntW'(2)) : (free_slots != '0));
    deq        = (count_q != '0) && resp_ready_i;
    enq_num    = {1'b0, ld_accept} + {1'b0, st_accept};
    st_ptr     = wr_ptr_q + PtrW'(ld_accept);

    id_mem_d = id_mem_q;
    ld_mem_d = ld_mem_q;
    if (ld_accept) begin
      id_mem_d[wr_ptr_q] = ld_resp_id_i;
      ld_mem_d[wr_ptr_q] = 1'b1;
    end
    if (st_accept) begin
      id_mem_d[st_ptr] = st_resp_id_i;
      ld_mem_d[st_ptr] = 1'b0;
    end

    wr_ptr_d   = wr_ptr_q + PtrW'(enq_num);
    rd_ptr_d   = rd_ptr_q + PtrW'(deq);
    count_d    = count_q + CntW'(enq_num) - CntW'(deq);
    overflow_d = overflow_q
               | (ld_resp_valid_i & ~ld_accept)
               | (st_resp_valid_i & ~st_accept);
  end

  // State registers; reset wipes all entries and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        id_mem_q[i] <= '0;
        ld_mem_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      id_mem_q   <= id_mem_d;
      ld_mem_q   <= ld_mem_d;
    end
  end

  // Outputs come straight from registered state; the stall threshold keeps
  // two slots in hand so a simultaneous load/store pair always fits.
  always_comb begin
    resp_valid_o   = (count_q != '0);
    resp_id_o      = id_mem_q[rd_ptr_q];
    resp_is_load_o = ld_mem_q[rd_ptr_q];
    req_stall_o    = (free_slots < CntW'(2));
    count_o        = count_q;
    overflow_o     = overflow_q;
  end

endmodule

// File: tb/tb_mlsu_resp_merger.sv
// Self-checking bench for mlsu_resp_merger: a table of hand-derived vectors
// for the directed scenarios, reset corner cases, then randomized traffic
// compared against a queue-based reference model.

module tb_mlsu_resp_merger;

  localparam int IdWidth = 5;
  localparam int Depth   = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               ld_resp_valid_i;
  logic [IdWidth-1:0] ld_resp_id_i;
  logic               st_resp_valid_i;
  logic [IdWidth-1:0] st_resp_id_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [IdWidth-1:0] resp_id_o;
  logic               resp_is_load_o;
  logic               req_stall_o;
  logic [3:0]         count_o;
  logic               overflow_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               is_load;
  } ent_t;

  typedef struct {
    logic               ld_v;
    logic [IdWidth-1:0] ld_id;
    logic               st_v;
    logic [IdWidth-1:0] st_id;
    logic               rdy;
    logic               e_valid;
    logic [IdWidth-1:0] e_id;
    logic               e_ld;
    int                 e_cnt;
    logic               e_stall;
    logic               e_ovf;
  } vec_t;

  ent_t model_q[$];
  logic model_ovf;
  vec_t vecs[$];

  mlsu_resp_merger #(.IdWidth(IdWidth), .Depth(Depth)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ld_resp_valid_i (ld_resp_valid_i),
    .ld_resp_id_i    (ld_resp_id_i),
    .st_resp_valid_i (st_resp_valid_i),
    .st_resp_id_i    (st_resp_id_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_id_o       (resp_id_o),
    .resp_is_load_o  (resp_is_load_o),
    .req_stall_o     (req_stall_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  function automatic void addVec(input logic ld_v, input int ld_id, input logic st_v,
                                 input int st_id, input logic rdy, input logic e_valid,
                                 input int e_id, input logic e_ld, input int e_cnt,
                                 input logic e_stall, input logic e_ovf);
    vec_t v;
    v.ld_v = ld_v;  v.ld_id = IdWidth'(ld_id);
    v.st_v = st_v;  v.st_id = IdWidth'(st_id);
    v.rdy = rdy;    v.e_valid = e_valid;
    v.e_id = IdWidth'(e_id); v.e_ld = e_ld;
    v.e_cnt = e_cnt; v.e_stall = e_stall; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  // Reference model: pulses fill the free room seen before the edge, load
  // first; dequeue removes the oldest pre-existing entry.
  task automatic modelStep();
    int  free_n;
    bit  deq;
    free_n = Depth - model_q.size();
    deq    = (model_q.size() > 0) && resp_ready_i;
    if (ld_resp_valid_i) begin
      if (free_n > 0) begin
        model_q.push_back('{id: ld_resp_id_i, is_load: 1'b1});
        free_n--;
      end else model_ovf = 1'b1;
    end
    if (st_resp_valid_i) begin
      if (free_n > 0) begin
        model_q.push_back('{id: st_resp_id_i, is_load: 1'b0});
        free_n--;
      end else model_ovf = 1'b1;
    end
    if (deq) void'(model_q.pop_front());
  endtask

  // Drive one cycle of inputs, clock them in, update the model, then settle
  // 1 ns past the edge and drop the one-cycle pulses.
  task automatic applyStimulus(input logic ld_v, input logic [IdWidth-1:0] ld_id,
                               input logic st_v, input logic [IdWidth-1:0] st_id,
                               input logic rdy);
    ld_resp_valid_i = ld_v;
    ld_resp_id_i    = ld_id;
    st_resp_valid_i = st_v;
    st_resp_id_i    = st_id;
    resp_ready_i    = rdy;
    @(posedge clk_i);
    if (!rst_i) modelStep();
    #1;
    ld_resp_valid_i = 1'b0;
    st_resp_valid_i = 1'b0;
  endtask

  task automatic cmp(input string name, input string field, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s %s got %0d want %0d", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [IdWidth-1:0] e_id,
                             input logic e_ld, input int e_cnt, input logic e_stall,
                             input logic e_ovf);
    cmp(name, "valid", int'(resp_valid_o), int'(e_valid));
    if (e_valid) begin
      cmp(name, "id", int'(resp_id_o), int'(e_id));
      cmp(name, "is_load", int'(resp_is_load_o), int'(e_ld));
    end
    cmp(name, "count", int'(count_o), e_cnt);
    cmp(name, "stall", int'(req_stall_o), int'(e_stall));
    cmp(name, "overflow", int'(overflow_o), int'(e_ovf));
  endtask

  task automatic checkModel(input string name);
    ent_t head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    checkOutput(name, model_q.size() > 0, head.id, head.is_load, model_q.size(),
                (Depth - model_q.size()) < 2, model_ovf);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    ld_resp_valid_i = 1'b0;
    st_resp_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    string nm;
    // Directed vectors: {ld_v, ld_id, st_v, st_id, rdy | valid, id, is_load, count, stall, ovf}
    addVec(1, 3, 0, 0, 1,  1, 3, 1, 1, 0, 0);   // single load visible next cycle
    addVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);   // consumed
    addVec(1, 1, 1, 2, 0,  1, 1, 1, 2, 0, 0);   // pair: load older
    addVec(0, 0, 0, 0, 1,  1, 2, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)                 // fill to 7; stall only at 7
      addVec(1, 10 + i, 0, 0, 0,  1, 10, 1, i + 1, (i == 6), 0);
    addVec(1, 4, 1, 5, 0,  1, 10, 1, 8, 1, 1);  // one slot: load kept, store dropped
    addVec(1, 20, 0, 0, 1,  1, 11, 1, 7, 1, 1); // full + dequeue: load still dropped
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 0, 0, 1,  1, 12 + i, 1, 6 - i, (6 - i) > 6, 1);
    addVec(0, 0, 0, 0, 1,  1, 4, 1, 1, 0, 1);   // tail is the kept load id 4
    addVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);

    rst_i = 1'b1;
    ld_resp_valid_i = 1'b0; ld_resp_id_i = '0;
    st_resp_valid_i = 1'b0; st_resp_id_i = '0;
    resp_ready_i = 1'b0;
    model_ovf = 1'b0;
    #1;
    checkOutput("reset_async", 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    cmp("reset_async", "id", int'(resp_id_o), 0);
    cmp("reset_async", "is_load", int'(resp_is_load_o), 0);
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld_v, vecs[i].ld_id, vecs[i].st_v, vecs[i].st_id, vecs[i].rdy);
      nm = $sformatf("vec%0d", i);
      checkOutput(nm, vecs[i].e_valid, vecs[i].e_id, vecs[i].e_ld, vecs[i].e_cnt,
                  vecs[i].e_stall, vecs[i].e_ovf);
    end

    // Mid-operation reset with a pulse under reset: nothing retained, no overflow.
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_mid", 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 1'b0);
    checkOutput("rst_pulse", 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    rst_i = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    // First edge after release accepts the enqueue.
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd21, 1'b0);
    checkOutput("post_rst", 1'b1, 5'd21, 1'b0, 1, 1'b0, 1'b0);
    // One free slot, lone store: accepted.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, IdWidth'(i), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 5'd30, 1'b0);
    checkModel("one_free_store");
    cmp("one_free_store", "overflow", int'(overflow_o), 0);

    // Alternating enqueue/dequeue across pointer wrap.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, IdWidth'(i), 1'b0, '0, 1'b0);
      checkModel($sformatf("alt_enq%0d", i));
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkModel($sformatf("alt_deq%0d", i));
    end

    // Randomized traffic against the model with shifting pressure.
    doReset();
    for (int i = 0; i < 600; i++) begin
      int ld_pct, st_pct, rdy_pct;
      ld_pct  = ((i / 100) % 2 == 0) ? 60 : 25;
      st_pct  = ((i / 100) % 2 == 0) ? 50 : 20;
      rdy_pct = ((i / 50) % 3 == 0) ? 10 : 70;
      applyStimulus($urandom_range(0, 99) < ld_pct, IdWidth'($urandom),
                    $urandom_range(0, 99) < st_pct, IdWidth'($urandom),
                    $urandom_range(0, 99) < rdy_pct);
      checkModel($sformatf("rand%0d", i));
      if (i == 300) begin
        rst_i = 1'b1;
        #1;
        checkOutput("rand_rst", 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        doReset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
